// File: rtl/dec_step_onehot.sv
// N-to-2^N one-hot decoder with registered outputs and a built-in step counter.
// Optional Done pulse on step-mode wrap: define DEC_STEP_DONE_EN.
module dec_step_onehot #(
    parameter int N    = 3,
    parameter int LAST = 2**N - 1
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            En,
    input  logic            Mode,
    input  logic            Clear,
    input  logic            Load,
    input  logic [N-1:0]    W,
    output logic [0:2**N-1] Y,
    output logic [N-1:0]    Step,
    output logic            Valid
`ifdef DEC_STEP_DONE_EN
    ,
    output logic            Done
`endif
);

    localparam int          OUT    = 2**N;
    localparam logic [N-1:0] LAST_C = N'(LAST);

    logic [N-1:0] step_q, step_d;
    logic         act_q;

`ifdef DEC_STEP_DONE_EN
    logic wrap_d;
    logic done_q;
`endif

    // Clear > Load (step mode only) > advance/direct capture > hold
    always_comb begin
        step_d = step_q;
`ifdef DEC_STEP_DONE_EN
        wrap_d = 1'b0;
`endif
        if (Clear) begin
            step_d = '0;
        end else if (Mode && Load) begin
            step_d = W;
        end else if (En) begin
            if (!Mode) begin
                step_d = W;
            end else if (step_q >= LAST_C) begin
                step_d = '0;
`ifdef DEC_STEP_DONE_EN
                wrap_d = 1'b1;
`endif
            end else begin
                step_d = step_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step_q <= '0;
            act_q  <= 1'b0;
        end else begin
            step_q <= step_d;
            act_q  <= En;
        end
    end

`ifdef DEC_STEP_DONE_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            done_q <= 1'b0;
        end else begin
            done_q <= wrap_d;
        end
    end

    assign Done = done_q;
`endif

    // Y is ascending-indexed: code k lands on Y[OUT-1-k]
    always_comb begin
        Y = '0;
        for (int k = 0; k < OUT; k++) begin
            Y[OUT-1-k] = act_q && (step_q == N'(k));
        end
    end

    assign Step  = step_q;
    assign Valid = act_q;

endmodule

// File: tb/tb_dec_step_onehot.sv
// Directed table-driven bench for dec_step_onehot.
// Instance u0 uses defaults (LAST=7); u4 uses LAST=4.
module tb_dec_step_onehot;

    logic       Clock = 1'b0;
    logic       run   = 1'b0;
    logic       Resetn = 1'b1;

    logic       en, mode, clr, ld;
    logic [2:0] w;
    logic [0:7] y;
    logic [2:0] st;
    logic       vld;

    logic       en4, mode4, clr4, ld4;
    logic [2:0] w4;
    logic [0:7] y4;
    logic [2:0] st4;
    logic       vld4;

`ifdef DEC_STEP_DONE_EN
    logic       done, done4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clock = run ? ~Clock : Clock;

    dec_step_onehot u0 (
        .Clock (Clock),
        .Resetn(Resetn),
        .En    (en),
        .Mode  (mode),
        .Clear (clr),
        .Load  (ld),
        .W     (w),
        .Y     (y),
        .Step  (st),
        .Valid (vld)
`ifdef DEC_STEP_DONE_EN
        ,
        .Done  (done)
`endif
    );

    dec_step_onehot #(.N(3), .LAST(4)) u4 (
        .Clock (Clock),
        .Resetn(Resetn),
        .En    (en4),
        .Mode  (mode4),
        .Clear (clr4),
        .Load  (ld4),
        .W     (w4),
        .Y     (y4),
        .Step  (st4),
        .Valid (vld4)
`ifdef DEC_STEP_DONE_EN
        ,
        .Done  (done4)
`endif
    );

    typedef struct {
        logic       en, mode, clr, ld;
        logic [2:0] w;
        logic [7:0] y;
        logic [2:0] st;
        logic       v;
        logic       d;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic drv4(input logic e, input logic m, input logic c,
                        input logic l, input logic [2:0] v);
        @(negedge Clock);
        en4 = e; mode4 = m; clr4 = c; ld4 = l; w4 = v;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        en = 0; mode = 0; clr = 0; ld = 0; w = 0;
        en4 = 0; mode4 = 0; clr4 = 0; ld4 = 0; w4 = 0;

        tbl[0]  = '{1, 0, 0, 0, 3'd5, 8'h20, 3'd5, 1, 0};
        tbl[1]  = '{0, 0, 0, 0, 3'd2, 8'h00, 3'd5, 0, 0};
        tbl[2]  = '{1, 0, 0, 1, 3'd3, 8'h08, 3'd3, 1, 0};
        tbl[3]  = '{1, 0, 1, 0, 3'd6, 8'h01, 3'd0, 1, 0};
        tbl[4]  = '{0, 1, 0, 0, 3'd0, 8'h00, 3'd0, 0, 0};
        tbl[5]  = '{1, 1, 1, 0, 3'd0, 8'h01, 3'd0, 1, 0};
        for (int i = 6; i <= 12; i++) begin
            tbl[i] = '{1, 1, 0, 0, 3'd0, 8'(1 << (i - 5)), 3'(i - 5), 1, 0};
        end
        tbl[13] = '{1, 1, 0, 0, 3'd0, 8'h01, 3'd0, 1, 1};
        tbl[14] = '{0, 1, 0, 1, 3'd6, 8'h00, 3'd6, 0, 0};
        tbl[15] = '{1, 1, 0, 0, 3'd0, 8'h80, 3'd7, 1, 0};
        tbl[16] = '{1, 1, 1, 1, 3'd3, 8'h01, 3'd0, 1, 0};
        tbl[17] = '{1, 1, 0, 1, 3'd3, 8'h08, 3'd3, 1, 0};
        tbl[18] = '{1, 0, 0, 0, 3'd4, 8'h10, 3'd4, 1, 0};
        tbl[19] = '{1, 1, 0, 0, 3'd0, 8'h20, 3'd5, 1, 0};
        tbl[20] = '{1, 1, 0, 1, 3'd3, 8'h08, 3'd3, 1, 0};

        // reset with the clock stopped
        #2 Resetn = 1'b0;
        #1;
        chk("rst_y", 32'(y), 32'h0);
        chk("rst_step", 32'(st), 32'h0);
        chk("rst_valid", 32'(vld), 32'h0);
`ifdef DEC_STEP_DONE_EN
        chk("rst_done", 32'(done), 32'h0);
`endif
        run = 1'b1;
        @(negedge Clock);
        Resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            #1;
            chk("idle_y", 32'(y), 32'h0);
            chk("idle_valid", 32'(vld), 32'h0);
        end

        for (int i = 0; i < 21; i++) begin
            @(negedge Clock);
            en = tbl[i].en; mode = tbl[i].mode;
            clr = tbl[i].clr; ld = tbl[i].ld; w = tbl[i].w;
            @(posedge Clock);
            #1;
            chk($sformatf("v%0d_y", i), 32'(y), 32'(tbl[i].y));
            chk($sformatf("v%0d_step", i), 32'(st), 32'(tbl[i].st));
            chk($sformatf("v%0d_valid", i), 32'(vld), 32'(tbl[i].v));
`ifdef DEC_STEP_DONE_EN
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].d));
`endif
        end

        // async reset between edges while at Step=3
        #1 Resetn = 1'b0;
        #1;
        chk("async_y", 32'(y), 32'h0);
        chk("async_step", 32'(st), 32'h0);
        chk("async_valid", 32'(vld), 32'h0);
        @(negedge Clock);
        en = 0; mode = 0; clr = 0; ld = 0; w = 0;
        Resetn = 1'b1;

        // LAST=4 instance
        drv4(1, 1, 1, 0, 3'd0);
        chk("l4_clr_step", 32'(st4), 32'h0);
        chk("l4_clr_y", 32'(y4), 32'h01);
        for (int i = 1; i <= 4; i++) begin
            drv4(1, 1, 0, 0, 3'd0);
            chk($sformatf("l4_adv%0d_step", i), 32'(st4), 32'(i));
            chk($sformatf("l4_adv%0d_y", i), 32'(y4), 32'(1 << i));
        end
        drv4(1, 1, 0, 0, 3'd0);
        chk("l4_wrap_step", 32'(st4), 32'h0);
        chk("l4_wrap_y", 32'(y4), 32'h01);
`ifdef DEC_STEP_DONE_EN
        chk("l4_wrap_done", 32'(done4), 32'h1);
`endif
        drv4(1, 1, 0, 1, 3'd6);
        chk("l4_ld6_step", 32'(st4), 32'h6);
        chk("l4_ld6_y", 32'(y4), 32'h40);
        drv4(1, 1, 0, 0, 3'd0);
        chk("l4_ld6_wrap", 32'(st4), 32'h0);
        drv4(0, 1, 0, 1, 3'd7);
        chk("l4_ld7_step", 32'(st4), 32'h7);
        chk("l4_ld7_y", 32'(y4), 32'h0);
        chk("l4_ld7_valid", 32'(vld4), 32'h0);
        drv4(1, 1, 0, 0, 3'd0);
        chk("l4_ld7_wrap", 32'(st4), 32'h0);
        chk("l4_ld7_wrap_y", 32'(y4), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
